// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, default sizes and small op-decode helpers.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } md_state_e;

  // Divide ops have bit 1 set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have bit 0 set.
  function automatic logic md_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign correction applied to the magnitude result in FIN.
// Multiply: negate the double-width product when operand signs differ.
// Divide: negate the quotient when signs differ; the remainder takes the
// dividend's sign. The most-negative / -1 case falls out naturally because
// negating 0x80000000 in two's complement yields 0x80000000.
module md_sign_fix import md_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] i_raw_hi,
  input  logic [WIDTH-1:0] i_raw_lo,
  input  logic [1:0]       i_op,
  input  logic             i_sign_a,
  input  logic             i_sign_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_hi_neg;
  logic [WIDTH-1:0]   w_lo_neg;

  assign w_prod_neg = ~{i_raw_hi, i_raw_lo} + ONE_2W;
  assign w_hi_neg   = ~i_raw_hi + ONE_W;
  assign w_lo_neg   = ~i_raw_lo + ONE_W;

  // Select corrected hi/lo per operation and operand signs.
  always_comb begin
    o_hi = i_raw_hi;
    o_lo = i_raw_lo;
    case (i_op)
      MD_MULTU: begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
      end
      MD_MULT: begin
        if (i_sign_a ^ i_sign_b) begin
          {o_hi, o_lo} = w_prod_neg;
        end else begin
          {o_hi, o_lo} = {i_raw_hi, i_raw_lo};
        end
      end
      MD_DIVU: begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
      end
      MD_DIV: begin
        if (i_sign_a ^ i_sign_b) begin
          o_lo = w_lo_neg;
        end else begin
          o_lo = i_raw_lo;
        end
        if (i_sign_a) begin
          o_hi = w_hi_neg;
        end else begin
          o_hi = i_raw_hi;
        end
      end
      default: begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative integer multiply/divide unit for the MIPS EX stage.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring shift-subtract,
// both on operand magnitudes, one iteration per clock, with sign correction
// in a final FIN cycle that writes HI/LO and pulses done.
// Optional build macro MD_EARLY_OUT_EN: a multiply leaves CALC as soon as the
// remaining multiplier bits are all zero (divide latency is unchanged).
module mult_div_unit import md_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [2*WIDTH-1:0] r_ma;       // multiplicand (shifts left) / dividend source
  logic [WIDTH-1:0]   r_mb;       // multiplier (shifts right) / divisor
  logic [2*WIDTH-1:0] r_acc;      // product, or {remainder, quotient}
  logic [WIDTH-1:0]   r_a_raw;    // a as presented, reported as HI on divide by zero
  logic               r_dbz_pend;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_div_acc;
  logic               w_last;
  logic               w_mb_rest_zero;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand magnitudes: signed ops take |x|, unsigned ops pass raw bits.
  assign w_abs_a = (md_is_signed(op) && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign w_abs_b = (md_is_signed(op) && b[WIDTH-1]) ? (~b + ONE_W) : b;

  // Shift-add step: add the shifted multiplicand when the current bit is set.
  assign w_mul_acc = r_mb[0] ? (r_acc + r_ma) : r_acc;

  // Restoring divide step: bring in the next dividend bit, trial-subtract.
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_ma[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_mb};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_div_acc = {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};

  assign w_last         = (r_cnt == CNT_LAST);
  assign w_mb_rest_zero = (r_mb[WIDTH-1:1] == {(WIDTH-1){1'b0}});

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_raw_hi (r_acc[2*WIDTH-1:WIDTH]),
    .i_raw_lo (r_acc[WIDTH-1:0]),
    .i_op     (r_op),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> CALC on start, CALC for the iterations, FIN once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
`ifdef MD_EARLY_OUT_EN
        if (w_last || (!md_is_div(r_op) && w_mb_rest_zero)) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CALC;
        end
`else
        if (w_last) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CALC;
        end
`endif
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 2'b00;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_ma       <= {(2*WIDTH){1'b0}};
      r_mb       <= {WIDTH{1'b0}};
      r_acc      <= {(2*WIDTH){1'b0}};
      r_a_raw    <= {WIDTH{1'b0}};
      r_dbz_pend <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op       <= op;
            r_sign_a   <= md_is_signed(op) & a[WIDTH-1];
            r_sign_b   <= md_is_signed(op) & b[WIDTH-1];
            r_ma       <= {{WIDTH{1'b0}}, w_abs_a};
            r_mb       <= w_abs_b;
            r_acc      <= {(2*WIDTH){1'b0}};
            r_a_raw    <= a;
            r_dbz_pend <= md_is_div(op) & (b == {WIDTH{1'b0}});
            r_cnt      <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_ONE;
          r_ma  <= {r_ma[2*WIDTH-2:0], 1'b0};
          if (md_is_div(r_op)) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc <= w_mul_acc;
            r_mb  <= {1'b0, r_mb[WIDTH-1:1]};
          end
        end
        FIN: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output registers: HI/LO/div_by_zero written in FIN, done pulses after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= 1'b0;
      if (r_state == FIN) begin
        r_done <= 1'b1;
        if (r_dbz_pend) begin
          r_hi  <= r_a_raw;
          r_lo  <= {WIDTH{1'b1}};
          r_dbz <= 1'b1;
        end else begin
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
          r_dbz <= 1'b0;
        end
      end else if ((r_state == IDLE) && start) begin
        r_dbz <= 1'b0;
      end else begin
        r_dbz <= r_dbz;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
